// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encodings, frame constants and parity helper.
package ps2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_DATA   = 4'd1,
    ST_PARITY = 4'd2,
    ST_STOP   = 4'd3,
    ST_DONE   = 4'd4
  } state_t;

  localparam int PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_ACK = 8'hFA;

  // Parity bit that makes the total count of ones (data + parity) odd.
  function automatic logic odd_parity(input logic [7:0] data_byte);
    return ~(^data_byte);
  endfunction

endpackage

// File: rtl/ps2_receive_if.sv
// Receiver result bus: the receiver drives it (master), the protocol controller reads it (slave).
interface ps2_receive_if;
  import ps2_pkg::*;

  logic [7:0] data_out;
  logic       valid;
  logic       err_parity;
  logic       err_frame;
  logic       err_timeout;
  logic       busy;
  state_t     status;

  modport master (
    output data_out, valid, err_parity, err_frame, err_timeout, busy, status
  );

  modport slave (
    input data_out, valid, err_parity, err_frame, err_timeout, busy, status
  );

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus glitch filter for one open-collector PS/2 line, with a 1->0 pulse.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic qzt_clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int CNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             level_reg;
  logic             fall_reg;

  // Level flips on the FILTER_LEN-th consecutive sample that disagrees with it.
  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= 2'b11;
      cnt_reg   <= '0;
      level_reg <= 1'b1;
      fall_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], line_in};
      fall_reg <= 1'b0;
      if (sync_reg[1] != level_reg) begin
        if (cnt_reg == CNT_W'(FILTER_LEN - 1)) begin
          level_reg <= sync_reg[1];
          cnt_reg   <= '0;
          fall_reg  <= level_reg;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign level = level_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/ps2_receive.sv
// Device-to-host PS/2 frame receiver: deframes start/8 data/odd parity/stop and strobes the result.
module ps2_receive
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 200
) (
  input  logic       qzt_clk,
  input  logic       rst_n,
  input  logic       PS2C,
  input  logic       PS2D,
  input  logic       inhibit,
  ps2_receive_if.master rx
);

  localparam int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int GAP_W          = $clog2(TIMEOUT_CYCLES + 1);

  logic c_fall;
  logic c_level_unused;
  logic d_level;
  logic d_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
    .qzt_clk (qzt_clk),
    .rst_n   (rst_n),
    .line_in (PS2C),
    .level   (c_level_unused),
    .fall    (c_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
    .qzt_clk (qzt_clk),
    .rst_n   (rst_n),
    .line_in (PS2D),
    .level   (d_level),
    .fall    (d_fall_unused)
  );

  state_t           state_reg, state_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic             parity_reg, parity_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic [7:0]       data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             errp_reg, errp_next;
  logic             errf_reg, errf_next;
  logic             errt_reg, errt_next;

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      gap_reg     <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      errp_reg    <= 1'b0;
      errf_reg    <= 1'b0;
      errt_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      gap_reg     <= gap_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      errp_reg    <= errp_next;
      errf_reg    <= errf_next;
      errt_reg    <= errt_next;
    end
  end

  // Frame verdict is decided on the stop-bit fall and registered, so it appears in ST_DONE.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    gap_next     = gap_reg;
    data_next    = data_reg;
    valid_next   = 1'b0;
    errp_next    = 1'b0;
    errf_next    = 1'b0;
    errt_next    = 1'b0;

    if (inhibit) begin
      state_next = ST_IDLE;
      gap_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          gap_next = '0;
          if (c_fall && !d_level) begin
            state_next   = ST_DATA;
            bit_cnt_next = '0;
          end
        end
        ST_DATA: begin
          gap_next = gap_reg + GAP_W'(1);
          if (c_fall) begin
            shift_next[bit_cnt_reg] = d_level;
            bit_cnt_next            = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) state_next = ST_PARITY;
          end
        end
        ST_PARITY: begin
          gap_next = gap_reg + GAP_W'(1);
          if (c_fall) begin
            parity_next = d_level;
            state_next  = ST_STOP;
          end
        end
        ST_STOP: begin
          gap_next = gap_reg + GAP_W'(1);
          if (c_fall) begin
            state_next = ST_DONE;
            if (odd_parity(shift_reg) != parity_reg) begin
              errp_next = 1'b1;
            end else if (!d_level) begin
              errf_next = 1'b1;
            end else begin
              data_next  = shift_reg;
              valid_next = 1'b1;
            end
          end
        end
        ST_DONE: begin
          gap_next   = '0;
          state_next = ST_IDLE;
        end
        default: begin
          gap_next   = '0;
          state_next = ST_IDLE;
        end
      endcase

      // A fall in the same cycle as the limit clears the counter and wins.
      if (c_fall) begin
        gap_next = '0;
      end else if ((state_reg == ST_DATA || state_reg == ST_PARITY || state_reg == ST_STOP)
                   && gap_reg == GAP_W'(TIMEOUT_CYCLES - 1)) begin
        errt_next  = 1'b1;
        state_next = ST_IDLE;
        gap_next   = '0;
      end
    end
  end

  assign rx.data_out    = data_reg;
  assign rx.valid       = valid_reg;
  assign rx.err_parity  = errp_reg;
  assign rx.err_frame   = errf_reg;
  assign rx.err_timeout = errt_reg;
  assign rx.busy        = (state_reg != ST_IDLE);
  assign rx.status      = state_reg;

endmodule
